q44_bcd_decoder: RTL

- Sequential decoder that turns an unsigned Q4.4 result from the team's fixed-point add/sub datapath into decimal BCD digits for display: two integer digits and up to four fractional digits.
- Sits between the arithmetic block and the 7-segment/display logic.
- Uses a start/busy/done handshake, so the combinational arithmetic output only needs to be valid in the cycle `start` is sampled.

---
 rtl/q44_bcd_decoder_if.sv | 25 ++
 rtl/q44_bcd_decoder.sv | 110 +++++++++++
 2 files changed

// File: rtl/q44_bcd_decoder_if.sv
// Handshake and result bus between the fixed-point datapath, the Q4.4 BCD
// decoder and the display logic.
interface q44_bcd_decoder_if;
    logic        start;
    logic [7:0]  q_in;
    logic        ovf_in;
    logic        busy;
    logic        done;
    logic [3:0]  int_tens;
    logic [3:0]  int_ones;
    logic [15:0] frac_bcd;
    logic        ovf_out;

    // Requester side: issues operands, observes the decoded digits.
    modport master (
        output start, q_in, ovf_in,
        input  busy, done, int_tens, int_ones, frac_bcd, ovf_out
    );

    // Decoder side.
    modport slave (
        input  start, q_in, ovf_in,
        output busy, done, int_tens, int_ones, frac_bcd, ovf_out
    );
endinterface

// File: rtl/q44_bcd_decoder.sv
// Sequential Q4.4 -> BCD decoder: double-dabble on the integer nibble,
// then repeated multiply-by-10 on the fraction, one digit per cycle.
module q44_bcd_decoder #(
    parameter int FRAC_DIGITS = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    q44_bcd_decoder_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INT  = 2'd1;
    localparam logic [1:0] S_FRAC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] LAST_FRAC = 3'(FRAC_DIGITS - 1);
    // Unused low digit positions are pushed out as zeros.
    localparam int         PAD_BITS  = 4 * (4 - FRAC_DIGITS);

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [11:0] sh;        // {tens, ones, binary integer nibble}
    logic [3:0]  frac_r;
    logic [15:0] acc;
    logic        ovf_lat;

    logic        busy_r, done_r, ovf_r;
    logic [3:0]  tens_r, ones_r;
    logic [15:0] frac_bcd_r;

    logic [11:0] sh_adj;
    logic [7:0]  prod;
    logic [15:0] acc_next;

    // Add-3 correction on both BCD nibbles before each shift.
    always_comb begin
        sh_adj = sh;
        if (sh[11:8] >= 4'd5) sh_adj[11:8] = sh[11:8] + 4'd3;
        if (sh[7:4]  >= 4'd5) sh_adj[7:4]  = sh[7:4]  + 4'd3;
    end

    // frac*10 as frac*8 + frac*2; high nibble is the next decimal digit.
    assign prod     = {1'b0, frac_r, 3'b000} + {3'b000, frac_r, 1'b0};
    assign acc_next = {acc[11:0], prod[7:4]};

    // Conversion FSM; visible outputs are only written on the final FRAC step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sh         <= '0;
            frac_r     <= '0;
            acc        <= '0;
            ovf_lat    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tens_r     <= '0;
            ones_r     <= '0;
            frac_bcd_r <= '0;
            ovf_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_INT;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        sh      <= {8'h00, bus.q_in[7:4]};
                        frac_r  <= bus.q_in[3:0];
                        acc     <= '0;
                        ovf_lat <= bus.ovf_in;
                    end
                end
                S_INT: begin
                    sh  <= {sh_adj[10:0], 1'b0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd3) begin
                        state <= S_FRAC;
                        cnt   <= '0;
                    end
                end
                S_FRAC: begin
                    frac_r <= prod[3:0];
                    acc    <= acc_next;
                    cnt    <= cnt + 3'd1;
                    if (cnt == LAST_FRAC) begin
                        state      <= S_DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        tens_r     <= sh[11:8];
                        ones_r     <= sh[7:4];
                        frac_bcd_r <= acc_next << PAD_BITS;
                        ovf_r      <= ovf_lat;
                    end
                end
                default: begin
                    // DONE: one cycle, start is not looked at here.
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.int_tens = tens_r;
    assign bus.int_ones = ones_r;
    assign bus.frac_bcd = frac_bcd_r;
    assign bus.ovf_out  = ovf_r;
endmodule
